pipeline_stall_controller: RTL and testbench
============================================

# pipeline_stall_controller

Central stall/flush sequencer for the 5-stage pipeline. It merges the load-use hazard flag from the hazard detection unit, the branch-taken flag from EXE, and the MEM-stage SRAM handshake into one consistent set of hold/flush controls for the pipeline registers. It also enforces an SRAM wait timeout and keeps saturating stall/flush performance counters. It sits beside the hazard detection unit and drives the PC, IF/ID, ID/EXE, EXE/MEM and MEM/WB register enables.

## Interface

Parameters:
- MAX_WAIT, 8: maximum consecutive frozen cycles per SRAM access before error (legal range ≥ 2).
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- hazard  in  1  load-use hazard from the hazard detection unit.
- branch_taken  in  1  EXE-stage branch resolved taken.
- mem_req  in  1  MEM-stage instruction performs an SRAM read or write.
- sram_ready  in  1  SRAM access completes this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- freeze_all  out  1  hold PC and all pipeline registers.
- pc_hold  out  1  hold PC.
- if_id_hold  out  1  hold the IF/ID register.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_exe_bubble  out  1  load a NOP into ID/EXE.
- mem_error  out  1  sticky SRAM timeout flag.
- stall_cnt  out  CNT_W  stalled-cycle count.
- flush_cnt  out  CNT_W  branch-flush count.

## Operation

- FSM states: RUN, MEM_WAIT, ERROR. Reset state is RUN.
- Internal wait_cnt, width clog2(MAX_WAIT+1), holds the number of frozen cycles already completed for the current access. It is 0 in RUN.
- mem_stall = mem_req & ~sram_ready, evaluated in RUN or MEM_WAIT.
- Output priority: ERROR > mem_stall > branch_taken > hazard > none.
- ERROR:
  - freeze_all = pc_hold = if_id_hold = 1.
  - Flush/bubble outputs are 0. mem_error = 1.
  - Exit only by reset.
- mem_stall:
  - freeze_all = pc_hold = if_id_hold = 1.
  - if_id_flush = id_exe_bubble = 0.
  - branch_taken and hazard are ignored, because EXE/ID are held and those inputs stay stable.
- branch_taken (not frozen): if_id_flush = id_exe_bubble = 1, holds 0. A simultaneous hazard is discarded, since the stalled instruction is itself flushed.
- hazard only: pc_hold = if_id_hold = id_exe_bubble = 1, freeze_all = 0.
- Otherwise all control outputs are 0.
- Transitions on rising clk:
  - RUN or MEM_WAIT with mem_stall:
    - If wait_cnt == MAX_WAIT-1, go to ERROR.
    - Else wait_cnt += 1 and go to MEM_WAIT.
  - MEM_WAIT without mem_stall (ready, or mem_req dropped): go to RUN, wait_cnt = 0.
  - RUN without mem_stall: stay in RUN.
- Counters:
  - stall_cnt increments in each cycle where pc_hold = 1 (this includes ERROR).
  - flush_cnt increments in each cycle where if_id_flush = 1.
  - Both saturate at 2^CNT_W − 1.
  - cnt_clr has priority over increment (value becomes 0 next cycle).

## Timing

- All control outputs are combinational from state and the current inputs (Mealy). A stall or flush applies in the same cycle as its cause.
- mem_error is registered (asserted as state == ERROR).
- Counters are registered: they update on the edge ending the counted cycle.
- Reset:
  - State = RUN, wait_cnt = 0, counters = 0, mem_error = 0.
  - While rst = 1, all combinational outputs are forced to 0.
  - Reset asserted mid-wait abandons the access immediately.
- SRAM completing in k cycles (k ≤ MAX_WAIT): freeze_all is high for k−1 cycles and low in the cycle where sram_ready = 1.
- sram_ready = 1 in the first cycle of mem_req: zero freeze cycles, FSM stays in RUN.
- Never ready: freeze_all is high for MAX_WAIT cycles in RUN/MEM_WAIT, then ERROR from the next cycle onward.
- Back-to-back accesses: the return to RUN resets wait_cnt, so each access gets a fresh MAX_WAIT budget.

## Test plan

- Reset then idle inputs → all outputs 0, counters 0. Assert rst asynchronously mid-cycle → outputs drop without waiting for a clk edge.
- hazard = 1 for 1 cycle, others 0 → pc_hold = if_id_hold = id_exe_bubble = 1 that cycle only; stall_cnt = 1 after the edge.
- branch_taken = 1 together with hazard = 1 → if_id_flush = id_exe_bubble = 1, pc_hold = 0; flush_cnt = 1, stall_cnt = 0.
- MAX_WAIT = 4, mem_req = 1, sram_ready = 1 on the 3rd cycle, branch_taken = 1 throughout → freeze_all = 1 in cycles 1–2, no flush in those cycles. Cycle 3: freeze_all = 0 and if_id_flush = 1. stall_cnt = 2, FSM back in RUN.
- MAX_WAIT = 4, mem_req = 1, sram_ready = 0 forever → freeze_all = 1 in cycles 1–4. mem_error = 1 from cycle 5 and stays 1 after mem_req drops, until rst.
- CNT_W = 2, hazard held high for 6 cycles with cnt_clr pulsed together with the 6th cycle → stall_cnt reads 1, 2, 3, 3, 3, then 0 after the 6th edge.

Source files
------------

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller
//   Merges load-use hazard, EXE branch-taken and the MEM-stage SRAM handshake
//   into one set of hold/flush controls for the 5-stage pipeline. It bounds
//   each SRAM access to MAX_WAIT frozen cycles and keeps saturating stall and
//   flush counters.
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   hazard           load-use hazard from the hazard detection unit
//   branch_taken     EXE-stage branch resolved taken
//   mem_req          MEM-stage instruction accesses SRAM
//   sram_ready       SRAM access completes this cycle
//   cnt_clr          synchronous clear of both counters
//   freeze_all       hold PC and every pipeline register
//   pc_hold          hold PC
//   if_id_hold       hold IF/ID
//   if_id_flush      load NOP into IF/ID
//   id_exe_bubble    load NOP into ID/EXE
//   mem_error        sticky SRAM timeout flag (cleared only by rst)
//   stall_cnt        cycles with pc_hold asserted
//   flush_cnt        cycles with if_id_flush asserted
module pipeline_stall_controller #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             sram_ready,
  input  logic             cnt_clr,
  output logic             freeze_all,
  output logic             pc_hold,
  output logic             if_id_hold,
  output logic             if_id_flush,
  output logic             id_exe_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t        state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic          mem_stall;

  // An access that is not ready yet freezes the whole pipe; not meaningful
  // once in ERROR, where the freeze is unconditional.
  assign mem_stall = mem_req & ~sram_ready & (state != ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
    end
  end

  always_comb begin
    state_n       = state;
    wait_n        = wait_cnt;
    freeze_all    = 1'b0;
    pc_hold       = 1'b0;
    if_id_hold    = 1'b0;
    if_id_flush   = 1'b0;
    id_exe_bubble = 1'b0;

    // Next state: wait_cnt counts frozen cycles already completed, so the
    // MAX_WAIT-th frozen cycle is the one that sees WAIT_LAST.
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt == WAIT_LAST) begin
            state_n = ERROR;
          end else begin
            wait_n  = wait_cnt + 1'b1;
            state_n = MEM_WAIT;
          end
        end else begin
          state_n = RUN;
          wait_n  = '0;
        end
      end
      default: state_n = ERROR;
    endcase

    // Controls, highest priority first. While frozen, EXE/ID are held so
    // branch_taken/hazard are stale and ignored. A taken branch flushes the
    // instruction that would have stalled, so hazard is dropped with it.
    if (!rst) begin
      if (state == ERROR || mem_stall) begin
        freeze_all = 1'b1;
        pc_hold    = 1'b1;
        if_id_hold = 1'b1;
      end else if (branch_taken) begin
        if_id_flush   = 1'b1;
        id_exe_bubble = 1'b1;
      end else if (hazard) begin
        pc_hold       = 1'b1;
        if_id_hold    = 1'b1;
        id_exe_bubble = 1'b1;
      end
    end
  end

  assign mem_error = (state == ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (pc_hold && stall_cnt != '1)     stall_cnt <= stall_cnt + 1'b1;
      if (if_id_flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller with MAX_WAIT=4, CNT_W=2.
// Inputs change 1 time unit after a rising edge; combinational outputs are
// sampled 1 unit later, registered outputs 1 unit after the following edge.
module tb_pipeline_stall_controller;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             hazard = 1'b0, branch_taken = 1'b0, mem_req = 1'b0;
  logic             sram_ready = 1'b0, cnt_clr = 1'b0;
  logic             freeze_all, pc_hold, if_id_hold, if_id_flush, id_exe_bubble;
  logic             mem_error;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_stall_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .hazard(hazard), .branch_taken(branch_taken),
    .mem_req(mem_req), .sram_ready(sram_ready), .cnt_clr(cnt_clr),
    .freeze_all(freeze_all), .pc_hold(pc_hold), .if_id_hold(if_id_hold),
    .if_id_flush(if_id_flush), .id_exe_bubble(id_exe_bubble),
    .mem_error(mem_error), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {freeze_all, pc_hold, if_id_hold, if_id_flush, id_exe_bubble}
  logic [4:0] ctrl;
  assign ctrl = {freeze_all, pc_hold, if_id_hold, if_id_flush, id_exe_bubble};

  typedef struct {
    logic       hz, br, mr, rdy;
    logic [4:0] exp_ctrl;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic hz, input logic br, input logic mr, input logic rdy);
    hazard = hz; branch_taken = br; mem_req = mr; sram_ready = rdy;
  endtask

  task automatic clear_cnts();
    set_in(0, 0, 0, 0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    int exp_sat[6];

    // ---- reset: outputs forced low even with hazard asserted ----
    hazard = 1'b1;
    #2;
    check("rst_ctrl_forced", ctrl, 0);
    @(posedge clk); #1;
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_flush_cnt", flush_cnt, 0);
    check("rst_mem_error", mem_error, 0);
    hazard = 1'b0;
    rst = 1'b0;
    tick();
    #1;
    check("idle_ctrl", ctrl, 0);

    // ---- single-cycle priority table (starting from RUN) ----
    vecs.push_back('{0, 0, 0, 0, 5'b00000, "idle"});
    vecs.push_back('{1, 0, 0, 0, 5'b01101, "hazard"});
    vecs.push_back('{0, 1, 0, 0, 5'b00011, "branch"});
    vecs.push_back('{1, 1, 0, 0, 5'b00011, "branch_hazard"});
    vecs.push_back('{0, 0, 1, 1, 5'b00000, "mem_ready"});
    vecs.push_back('{1, 0, 1, 1, 5'b01101, "mem_ready_hazard"});
    vecs.push_back('{0, 1, 1, 1, 5'b00011, "mem_ready_branch"});
    vecs.push_back('{1, 1, 1, 0, 5'b11100, "mem_stall_ignores"});
    vecs.push_back('{0, 0, 0, 0, 5'b00000, "wait_abandon_idle"});
    vecs.push_back('{0, 0, 0, 1, 5'b00000, "ready_no_req"});
    foreach (vecs[i]) begin
      set_in(vecs[i].hz, vecs[i].br, vecs[i].mr, vecs[i].rdy);
      #1;
      check({"vec_", vecs[i].name}, ctrl, vecs[i].exp_ctrl);
      tick();
    end

    // ---- hazard for one cycle ----
    clear_cnts();
    set_in(1, 0, 0, 0);
    #1; check("hz1_ctrl", ctrl, 5'b01101);
    tick();
    set_in(0, 0, 0, 0);
    #1; check("hz1_ctrl_after", ctrl, 0);
    check("hz1_stall_cnt", stall_cnt, 1);
    check("hz1_flush_cnt", flush_cnt, 0);

    // ---- branch with hazard ----
    clear_cnts();
    set_in(1, 1, 0, 0);
    #1; check("bh_ctrl", ctrl, 5'b00011);
    tick();
    set_in(0, 0, 0, 0);
    #1; check("bh_flush_cnt", flush_cnt, 1);
    check("bh_stall_cnt", stall_cnt, 0);

    // ---- SRAM ready on 3rd cycle, branch held throughout ----
    clear_cnts();
    for (int c = 1; c <= 2; c++) begin
      set_in(0, 1, 1, 0);
      #1; check($sformatf("wait3_c%0d_ctrl", c), ctrl, 5'b11100);
      tick();
    end
    set_in(0, 1, 1, 1);
    #1; check("wait3_c3_ctrl", ctrl, 5'b00011);
    tick();
    set_in(0, 0, 0, 0);
    #1; check("wait3_stall_cnt", stall_cnt, 2);
    check("wait3_flush_cnt", flush_cnt, 1);
    check("wait3_mem_error", mem_error, 0);

    // ---- never ready: fresh budget of MAX_WAIT freeze cycles, then ERROR ----
    clear_cnts();
    for (int c = 1; c <= MAX_WAIT; c++) begin
      set_in(0, 0, 1, 0);
      #1; check($sformatf("to_c%0d_ctrl", c), ctrl, 5'b11100);
      check($sformatf("to_c%0d_err", c), mem_error, 0);
      tick();
    end
    #1; check("to_err_set", mem_error, 1);
    check("to_err_ctrl", ctrl, 5'b11100);
    tick();
    set_in(1, 1, 0, 0);
    #1; check("to_err_sticky", mem_error, 1);
    check("to_err_ctrl_noreq", ctrl, 5'b11100);
    check("to_stall_sat", stall_cnt, 3);
    check("to_flush_none", flush_cnt, 0);
    tick();
    check("to_err_sticky2", mem_error, 1);

    // ---- asynchronous reset mid-cycle ----
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_ctrl", ctrl, 0);
    check("async_rst_err", mem_error, 0);
    check("async_rst_stall", stall_cnt, 0);
    set_in(0, 0, 0, 0);
    #1;
    rst = 1'b0;
    tick();

    // ---- counter saturation at CNT_W=2 with clear on the 6th cycle ----
    exp_sat = '{1, 2, 3, 3, 3, 0};
    clear_cnts();
    set_in(1, 0, 0, 0);
    for (int c = 0; c < 6; c++) begin
      cnt_clr = (c == 5);
      tick();
      check($sformatf("sat_c%0d_stall", c + 1), stall_cnt, exp_sat[c]);
    end
    cnt_clr = 1'b0;
    set_in(0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
